// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with valid/ready handshake and multi-cycle mult/div hold.
// Optional shift decode under alu_op 2 is enabled by defining ALU_CTRL_SHIFT_EN.
module alu_control_seq #(
  parameter int FUNC_W    = 6,
  parameter int ALUOP_W   = 3,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNC_W-1:0]  func,
  input  logic [ALUOP_W-1:0] alu_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_control,
  output logic               jr_sel,
  output logic               illegal,
  output logic               md_start,
  output logic               md_busy
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    MD_BUSY = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              jr;
    logic              ill;
    logic              md;
  } dec_t;

  function automatic dec_t decode(input logic [ALUOP_W-1:0] op, input logic [FUNC_W-1:0] fn);
    dec_t d;
    d.ctrl = '0;
    d.jr   = 1'b0;
    d.ill  = 1'b0;
    d.md   = 1'b0;
    case (op)
      ALUOP_W'(3'd0): d.ctrl = CTRL_W'(4'd2);
      ALUOP_W'(3'd1): d.ctrl = CTRL_W'(4'd6);
      ALUOP_W'(3'd3): d.ctrl = CTRL_W'(4'd1);
      ALUOP_W'(3'd4): d.ctrl = CTRL_W'(4'd13);
      ALUOP_W'(3'd2): begin
        case (fn)
          FUNC_W'(6'd32), FUNC_W'(6'd33): d.ctrl = CTRL_W'(4'd2);
          FUNC_W'(6'd34), FUNC_W'(6'd35): d.ctrl = CTRL_W'(4'd6);
          FUNC_W'(6'd36): d.ctrl = CTRL_W'(4'd0);
          FUNC_W'(6'd37): d.ctrl = CTRL_W'(4'd1);
          FUNC_W'(6'd39): d.ctrl = CTRL_W'(4'd12);
          FUNC_W'(6'd42): d.ctrl = CTRL_W'(4'd7);
          FUNC_W'(6'd8):  d.jr   = 1'b1;
          FUNC_W'(6'd24), FUNC_W'(6'd25): begin
            d.ctrl = CTRL_W'(4'd8);
            d.md   = 1'b1;
          end
          FUNC_W'(6'd26), FUNC_W'(6'd27): begin
            d.ctrl = CTRL_W'(4'd9);
            d.md   = 1'b1;
          end
`ifdef ALU_CTRL_SHIFT_EN
          FUNC_W'(6'd0), FUNC_W'(6'd4): d.ctrl = CTRL_W'(4'd13);
          FUNC_W'(6'd2), FUNC_W'(6'd6): d.ctrl = CTRL_W'(4'd14);
          FUNC_W'(6'd3), FUNC_W'(6'd7): d.ctrl = CTRL_W'(4'd15);
`endif
          default: d.ill = 1'b1;
        endcase
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CTRL_W-1:0] ctrl_r, ctrl_s;
  logic              jr_r, jr_s;
  logic              ill_r, ill_s;
  logic              out_valid_r, md_start_r, md_busy_r, md_start_s;
  logic              in_ready_s, accept_s;
  dec_t              dec_s;

  assign in_ready_s  = !flush && (state_r != MD_BUSY) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign alu_control = ctrl_r;
  assign jr_sel      = jr_r;
  assign illegal     = ill_r;
  assign md_start    = md_start_r;
  assign md_busy     = md_busy_r;

  // Next-state, counter and decoded-field selection.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ctrl_s     = ctrl_r;
    jr_s       = jr_r;
    ill_s      = ill_r;
    md_start_s = 1'b0;
    dec_s      = decode(alu_op, func);
    if (flush) begin
      state_s = IDLE;
      cnt_s   = '0;
    end else if (accept_s) begin
      ctrl_s = dec_s.ctrl;
      jr_s   = dec_s.jr;
      ill_s  = dec_s.ill;
      if (dec_s.md) begin
        state_s    = MD_BUSY;
        cnt_s      = CNT_W'(MD_CYCLES);
        md_start_s = 1'b1;
      end else begin
        state_s = HOLD;
        cnt_s   = '0;
      end
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        HOLD: begin
          if (out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = HOLD;
          end
        end
        MD_BUSY: begin
          // Last busy cycle is when the counter reads one; the result is presented next.
          if (cnt_r <= CNT_W'(1'b1)) begin
            state_s = HOLD;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r - CNT_W'(1'b1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      ctrl_r      <= '0;
      jr_r        <= 1'b0;
      ill_r       <= 1'b0;
      out_valid_r <= 1'b0;
      md_start_r  <= 1'b0;
      md_busy_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ctrl_r      <= ctrl_s;
      jr_r        <= jr_s;
      ill_r       <= ill_s;
      out_valid_r <= (state_s == HOLD);
      md_start_r  <= md_start_s;
      md_busy_r   <= (state_s == MD_BUSY);
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq (MD_CYCLES=4).
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [5:0] func;
  logic [2:0] alu_op;
  wire        in_ready, out_valid, jr_sel, illegal, md_start, md_busy;
  wire  [3:0] alu_control;
  wire  [8:0] obs;
  int         total = 0;
  int         bad   = 0;

`ifdef ALU_CTRL_SHIFT_EN
  localparam logic [3:0] SRL_CTRL = 4'd14;
  localparam logic [3:0] SRA_CTRL = 4'd15;
  localparam logic       SH_ILL   = 1'b0;
`else
  localparam logic [3:0] SRL_CTRL = 4'd0;
  localparam logic [3:0] SRA_CTRL = 4'd0;
  localparam logic       SH_ILL   = 1'b1;
`endif

  // {out_valid, alu_control, jr_sel, illegal, md_start, md_busy}
  assign obs = {out_valid, alu_control, jr_sel, illegal, md_start, md_busy};

  always #5 clk = ~clk;

  alu_control_seq #(.FUNC_W(6), .ALUOP_W(3), .CTRL_W(4), .MD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .jr_sel(jr_sel), .illegal(illegal),
    .md_start(md_start), .md_busy(md_busy)
  );

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    func = 6'd0; alu_op = 3'd0;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== 9'd0) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, 9'd0); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'd0; func = 6'd0; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
    @(negedge clk);
    total++;
    if (obs !== {1'b1, 4'd2, 4'b0000}) begin bad++; $display("FAIL b2b_first: got %b want %b", obs, {1'b1, 4'd2, 4'b0000}); end
    alu_op = 3'd1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
    @(negedge clk);
    total++;
    if (obs !== {1'b1, 4'd6, 4'b0000}) begin bad++; $display("FAIL b2b_second: got %b want %b", obs, {1'b1, 4'd6, 4'b0000}); end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_decode;
    logic [2:0] ops  [14] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
    logic [5:0] fns  [14] = '{6'd8, 6'd8, 6'd0, 6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd63, 6'd2, 6'd7, 6'd8};
    logic [3:0] ctls [14] = '{4'd0, 4'd1, 4'd13, 4'd0, 4'd0, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7, 4'd0, SRL_CTRL, SRA_CTRL, 4'd6};
    logic       jrs  [14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ills [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SH_ILL, SH_ILL, 1'b0};
    logic [8:0] exp_v;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_op = ops[i]; func = fns[i]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp_v = {1'b1, ctls[i], jrs[i], ills[i], 2'b00};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL decode[%0d] op=%0d func=%0d: got %b want %b", i, ops[i], fns[i], obs, exp_v);
      end
    end
  endtask

  task automatic test_md;
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'd2; func = 6'd24; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL md_accept_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b0, 4'd8, 4'b0011}) begin bad++; $display("FAIL md_start_cycle: got %b want %b", obs, {1'b0, 4'd8, 4'b0011}); end
    for (int c = 1; c < 4; c++) begin
      in_valid = (c < 3); alu_op = 3'd0;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL md_busy_ready[%0d]: got %b want 0", c, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (obs !== {1'b0, 4'd8, 4'b0001}) begin bad++; $display("FAIL md_busy[%0d]: got %b want %b", c, obs, {1'b0, 4'd8, 4'b0001}); end
    end
    @(negedge clk);
    total++;
    if (obs !== {1'b1, 4'd8, 4'b0000}) begin bad++; $display("FAIL md_result: got %b want %b", obs, {1'b1, 4'd8, 4'b0000}); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL md_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_hold;
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'd2; func = 6'd42; out_ready = 1'b0;
    @(negedge clk);
    alu_op = 3'd0; func = 6'd0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready: got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    total++;
    if (obs !== {1'b1, 4'd7, 4'b0000}) begin bad++; $display("FAIL hold_stable: got %b want %b", obs, {1'b1, 4'd7, 4'b0000}); end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 4'd2, 4'b0000}) begin bad++; $display("FAIL hold_next: got %b want %b", obs, {1'b1, 4'd2, 4'b0000}); end
    @(negedge clk);
  endtask

  task automatic test_flush_md;
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'd2; func = 6'd26; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (md_busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", md_busy); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_op = 3'd0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, md_start, md_busy} !== 3'b000) begin bad++; $display("FAIL flush_idle: got %b want 000", {out_valid, md_start, md_busy}); end
    repeat (5) @(negedge clk);
    total++;
    if ({out_valid, md_busy, in_ready} !== 3'b001) begin bad++; $display("FAIL flush_after: got %b want 001", {out_valid, md_busy, in_ready}); end
  endtask

  task automatic test_rst_midstream;
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'd2; func = 6'd25; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 9'd0) begin bad++; $display("FAIL rst_async: got %b want %b", obs, 9'd0); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (obs !== 9'd0) begin bad++; $display("FAIL rst_quiet: got %b want %b", obs, 9'd0); end
    in_valid = 1'b1; alu_op = 3'd2; func = 6'd32;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 4'd2, 4'b0000}) begin bad++; $display("FAIL rst_then_add: got %b want %b", obs, {1'b1, 4'd2, 4'b0000}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_decode();
    test_md();
    test_hold();
    test_flush_md();
    test_rst_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
